// File: rtl/ui_pkg.sv
// Shared state encoding, key-index constants and key priority helper for the
// monitor display entry controller.
package ui_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_ENTRY = 2'd1,
    ST_ADDR  = 2'd2
  } ui_state_e;

  localparam int NUM_KEYS  = 16;
  localparam int KEY_IDX_W = 4;

  typedef logic [KEY_IDX_W-1:0] key_idx_t;

  // Several keys hit together resolve to the lowest-numbered one.
  function automatic key_idx_t lowest_key(input logic [NUM_KEYS-1:0] keys);
    key_idx_t idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) idx = key_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ui_entry_ctrl_if.sv
// Keypad, monitor command and display signals of the entry controller; the
// master side drives the keys, the slave side (the controller) drives the display.
interface ui_entry_ctrl_if
  import ui_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int ADDR_W = 16
);
  localparam int CNT_W = $clog2(DIGITS + 1);

  logic [NUM_KEYS-1:0] keys;
  logic                b_back;
  logic                b_load;
  logic                b_storeinc;
  logic                b_dec;
  logic                clear_disp;
  logic                stopped;
  logic [ADDR_W-1:0]   addr;
  logic [4*DIGITS-1:0] disp;
  logic [DIGITS-1:0]   disp_blank;
  logic                disp_valid;
  logic [CNT_W-1:0]    digit_cnt;
  logic                key_evt;

  modport master (
    output keys, b_back, b_load, b_storeinc, b_dec, clear_disp, stopped, addr,
    input  disp, disp_blank, disp_valid, digit_cnt, key_evt
  );

  modport slave (
    input  keys, b_back, b_load, b_storeinc, b_dec, clear_disp, stopped, addr,
    output disp, disp_blank, disp_valid, digit_cnt, key_evt
  );

endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector for a level input; a level already high when reset
// releases must drop once before it can produce an edge.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev_q, prev_d;
  logic armed_q, armed_d;

  always_comb begin
    prev_d  = din;
    armed_d = armed_q | ~din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign rise = armed_q & din & ~prev_q;

endmodule

// File: rtl/ui_entry_ctrl.sv
// Hex keypad entry controller for a monitor display: digit shift-in, backspace,
// address display mode and clear-on-next-digit, with registered display outputs.
module ui_entry_ctrl
  import ui_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int ADDR_W = 16
) (
  input logic           clk,
  input logic           rst,
  ui_entry_ctrl_if.slave bus
);

  localparam int                DISP_W      = 4 * DIGITS;
  localparam int                CNT_W       = $clog2(DIGITS + 1);
  localparam logic [DIGITS-1:0] CLEAR_BLANK = {{(DIGITS-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(DIGITS);

  ui_state_e           state_q, state_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                key_evt_q, key_evt_d;
  logic                pend_q, pend_d;
  logic                fresh_q, fresh_d;
  logic [NUM_KEYS-1:0] keys_prev_q, keys_prev_d;
  logic                keys_arm_q, keys_arm_d;

  logic     hex_evt, bs_rise, bs_evt, stop_rise, clr_ok;
  key_idx_t hex_val;

  edge_detect u_bs_edge   (.clk(clk), .rst(rst), .din(bus.b_back),  .rise(bs_rise));
  edge_detect u_stop_edge (.clk(clk), .rst(rst), .din(bus.stopped), .rise(stop_rise));

  // Input edge stage: rollover-free hex press detection and command qualification
  always_comb begin
    keys_prev_d = bus.keys;
    keys_arm_d  = keys_arm_q | (bus.keys == '0);
    hex_evt     = keys_arm_q && (bus.keys != '0) && (keys_prev_q == '0);
    hex_val     = lowest_key(bus.keys);
    bs_evt      = bs_rise && !hex_evt;
    clr_ok      = bus.clear_disp && !bus.b_storeinc && !bus.b_dec;
  end

  // Next-state and display update
  always_comb begin
    state_d   = state_q;
    disp_d    = disp_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    fresh_d   = fresh_q;
    key_evt_d = 1'b0;

    if (stop_rise) begin
      state_d = ST_CLEAR;
      disp_d  = '0;
      cnt_d   = '0;
      pend_d  = 1'b0;
      fresh_d = 1'b1;
    end else if (bus.b_load) begin
      state_d = ST_ADDR;
      fresh_d = 1'b0;
      // A held load key keeps an already armed clear request alive.
      pend_d  = (state_q == ST_ADDR) ? (pend_q | clr_ok) : clr_ok;
    end else begin
      if (hex_evt) begin
        key_evt_d = 1'b1;
        fresh_d   = 1'b0;
        if (state_q == ST_CLEAR || pend_q) begin
          state_d = ST_ENTRY;
          disp_d  = DISP_W'(hex_val);
          cnt_d   = CNT_W'(1);
          pend_d  = 1'b0;
        end else if (state_q == ST_ENTRY) begin
          disp_d = {disp_q[DISP_W-5:0], hex_val};
          cnt_d  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
        end else begin
          disp_d = DISP_W'(bus.addr);
          cnt_d  = '0;
        end
      end else if (bs_evt) begin
        pend_d = 1'b0;
        if (state_q == ST_ENTRY) begin
          disp_d = disp_q >> 4;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_CLEAR;
        end
      end

      if (bus.clear_disp) begin
        if (state_q == ST_ENTRY) begin
          pend_d = 1'b1;
        end else if (state_q == ST_ADDR && clr_ok) begin
          state_d = ST_CLEAR;
          pend_d  = 1'b0;
        end
      end
    end

    valid_d = !(state_d == ST_CLEAR && fresh_d);
  end

  always_comb begin
    blank_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      unique case (state_d)
        ST_ENTRY: blank_d[i] = (i >= int'(cnt_d));
        ST_ADDR:  blank_d[i] = (i >= ADDR_W / 4);
        default:  blank_d[i] = (i != 0);
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_CLEAR;
    else     state_q <= state_d;
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q      <= '0;
      blank_q     <= CLEAR_BLANK;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      key_evt_q   <= 1'b0;
      pend_q      <= 1'b0;
      fresh_q     <= 1'b1;
      keys_prev_q <= '0;
      keys_arm_q  <= 1'b0;
    end else begin
      disp_q      <= disp_d;
      blank_q     <= blank_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      key_evt_q   <= key_evt_d;
      pend_q      <= pend_d;
      fresh_q     <= fresh_d;
      keys_prev_q <= keys_prev_d;
      keys_arm_q  <= keys_arm_d;
    end
  end

  assign bus.disp       = disp_q;
  assign bus.disp_blank = blank_q;
  assign bus.digit_cnt  = cnt_q;
  assign bus.disp_valid = valid_q;
  assign bus.key_evt    = key_evt_q;

endmodule

// File: doc/ui_entry_ctrl.md
UI_ENTRY_CTRL -- requirements
Module: ui_entry_ctrl

Interface
REQ-001 Parameter DIGITS, default 6: number of hex display digits; legal range 2..8.
REQ-002 Parameter ADDR_W, default 16: address width; SHALL be a multiple of 4 and no greater than 4*DIGITS.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; asynchronous assert, active-high.
REQ-005 keys  in  16  hex keypad levels; bit i means key i is held.
REQ-006 b_back  in  1  backspace key level.
REQ-007 b_load, b_storeinc, b_dec  in  1 each  monitor command key levels.
REQ-008 clear_disp  in  1  one-cycle request to clear on the next digit.
REQ-009 stopped  in  1  CPU-halted level.
REQ-010 addr  in  ADDR_W  current monitor address.
REQ-011 disp  out  4*DIGITS  displayed value; digit 0 is the LSB nibble.
REQ-012 disp_blank  out  DIGITS  per-digit blanking mask; 1 means blank.
REQ-013 disp_valid  out  1  display content is meaningful.
REQ-014 digit_cnt  out  clog2(DIGITS+1)  number of user-entered digits.
REQ-015 key_evt  out  1  one-cycle pulse for each accepted hex press.

Function
REQ-016 A hex press event SHALL fire only when keys is nonzero this cycle and was all-zero last cycle.
  - No auto-repeat while a key is held.
  - Simultaneous keys resolve to the lowest index.
REQ-017 A backspace event SHALL fire on the rising edge of b_back.
  - A backspace edge coincident with a hex event is ignored.
REQ-018 FSM states: CLEAR, ENTRY, ADDR; the reset state SHALL be CLEAR.
REQ-019 CLEAR + hex event d SHALL set:
  - disp = d zero-extended;
  - digit_cnt = 1;
  - state -> ENTRY.
REQ-020 ENTRY + hex event d SHALL shift disp left 4 bits, insert d at digit 0, drop the MSB digit, and saturate digit_cnt at DIGITS.
REQ-021 ENTRY + backspace SHALL shift disp right 4 bits (zero fill) and decrement digit_cnt.
  - When digit_cnt reaches 0, state -> CLEAR.
REQ-022 CLEAR + backspace SHALL be ignored.
REQ-023 A b_load level SHALL force state -> ADDR.
  - Same-cycle clear_disp with b_storeinc and b_dec both low SHALL also force state -> CLEAR at the next key event.
REQ-024 ADDR + hex event SHALL load disp = addr zero-extended and set digit_cnt = 0.
  - The FSM SHALL remain in ADDR.
REQ-025 clear_disp in ENTRY SHALL set a pending flag.
  - The next hex event SHALL then behave as in CLEAR and clear the flag.
  - A backspace event SHALL also clear the flag.
REQ-026 In ADDR, clear_disp with b_storeinc=b_dec=0 SHALL leave ADDR for CLEAR without changing disp.
REQ-027 The rising edge of stopped SHALL override all other events in that cycle:
  - disp = 0;
  - digit_cnt = 0;
  - pending flag cleared;
  - state -> CLEAR.
REQ-028 disp_blank[i] SHALL be 1 when:
  - in ENTRY with i >= digit_cnt;
  - in ADDR with i >= ADDR_W/4;
  - in CLEAR for every i except i = 0.
REQ-029 disp_valid SHALL be 1 except in CLEAR before the first event following reset or a stopped edge.
REQ-030 key_evt SHALL pulse in the same cycle disp updates for an accepted hex event.
REQ-031 All outputs SHALL be registered; latency from a key edge to the disp update is 1 clk.

Reset
REQ-032 Asserting rst SHALL immediately force:
  - disp = 0, disp_blank = all ones except bit 0;
  - disp_valid = 0, digit_cnt = 0, key_evt = 0;
  - state CLEAR, pending flag = 0, edge history registers = 0.
REQ-033 A key held across reset deassertion SHALL NOT generate an event until it is released and pressed again.

Structure
REQ-034 The FSM state enum and the key-index constants SHALL live in the shared package ui_pkg.
REQ-035 Edge detection on stopped and b_back SHALL use one sub-module, edge_detect, instantiated per signal; hex-key rollover detection stays inline.

Verification
REQ-036 DIGITS=6: press 1,2,3,4,5,6,7 -> disp=0x234567, digit_cnt=6, seven key_evt pulses.
REQ-037 Enter A,B,C, then backspace x3 -> disp 0xAB, 0xA, 0x0; state CLEAR; a fourth backspace has no effect.
REQ-038 Hold key 5, press key 3, release both, press 9 -> only two events (5, 9); disp=0x59.
REQ-039 b_load, addr=0x1F2E, press 7 -> disp=0x001F2E, disp_blank=0b110000; clear_disp with b_dec=1 keeps ADDR.
REQ-040 Enter 0x42, clear_disp, press 8 -> disp=0x8; raising stopped in the same cycle as a key press -> disp=0, state CLEAR.
